// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder_pkg: FSM states and chunk sizing helpers for multicycle_adder_ctrl.
package multicycle_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int ceil_div(int w, int c);
    return (w + c - 1) / c;
  endfunction
  function automatic int last_w(int w, int c);
    return w - (ceil_div(w, c) - 1) * c;
  endfunction
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multicycle_adder_ctrl_chunk_select_add.sv
// chunk_select_add: combinational carry-select slice, a+b and a+b+1 chosen by s.
module chunk_select_add #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             s,
  output logic [CHUNK-1:0] o,
  output logic             c
);
  logic [CHUNK:0] s0, s1;
  always_comb begin
    s0 = {1'b0, a} + {1'b0, b};
    s1 = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(1);
    {c, o} = s ? s1 : s0;
  end
endmodule

// File: rtl/multicycle_adder_ctrl.sv
// multicycle_adder_ctrl: WIDTH-bit add over NCHUNK cycles through one shared CHUNK-bit slice.
// Optional subtract mode (in_sub port) is enabled by defining MULTICYCLE_ADDER_SUB_EN.
module multicycle_adder_ctrl
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             busy
);
  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int LAST_W = last_w(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = idx_w(NCHUNK);
  state_t state_q, state_d;
  logic [PW-1:0] a_q, b_q, o_q;
  logic [IW-1:0] idx_q;
  logic [CHUNK-1:0] sa, sb, sum;
  logic [CHUNK:0] ext;
  logic carry_q, c, sub, accept, last;
`ifdef MULTICYCLE_ADDER_SUB_EN
  assign sub = in_sub;
`else
  assign sub = 1'b0;
`endif
  assign accept = (state_q == IDLE) && in_valid;
  assign last   = idx_q == IW'(NCHUNK - 1);
  assign o      = o_q[WIDTH-1:0];
  assign ext    = {c, sum};
  always_comb begin
    state_d   = state_q;
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    if (accept) state_d = RUN;
    else if (state_q == RUN && last) state_d = DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NCHUNK; i++)
      if (idx_q == IW'(i)) begin
        sa = a_q[i*CHUNK +: CHUNK];
        sb = b_q[i*CHUNK +: CHUNK];
      end
  end
  chunk_select_add #(.CHUNK(CHUNK)) u_slice (.a(sa), .b(sb), .s(carry_q), .o(sum), .c(c));
  // a padded last chunk has zero operand bits above LAST_W, so sum bit LAST_W is the true carry-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      o_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= PW'(a);
        b_q     <= PW'(b ^ {WIDTH{sub}});
        carry_q <= sub | cin;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        for (int i = 0; i < NCHUNK; i++)
          if (idx_q == IW'(i)) o_q[i*CHUNK +: CHUNK] <= sum;
        carry_q <= c;
        idx_q   <= idx_q + 1'b1;
        if (last) cout <= ext[LAST_W];
      end
    end
  end
endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// tb_multicycle_adder_ctrl: scoreboard bench for a 128/32 instance and a padded 40/16 instance.
module tb_multicycle_adder_ctrl;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic iv0 = 0, ir0, ov0, or0 = 0, cin0 = 0, c0, busy0;
  logic [127:0] a0 = 0, b0 = 0, o0;
  logic iv1 = 0, ir1, ov1, or1 = 1, cin1 = 0, c1, busy1;
  logic [39:0] a1 = 0, b1 = 0, o1;
`ifdef MULTICYCLE_ADDER_SUB_EN
  logic sub0 = 0, sub1 = 0;
`endif
  int total = 0, bad = 0;
  bit rnd = 0;
  logic [128:0] q0[$];
  logic [40:0] q1[$];

  multicycle_adder_ctrl #(.WIDTH(128), .CHUNK(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .in_sub(sub0),
`endif
    .out_valid(ov0), .out_ready(or0), .o(o0), .cout(c0), .busy(busy0));

  multicycle_adder_ctrl #(.WIDTH(40), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .in_sub(sub1),
`endif
    .out_valid(ov1), .out_ready(or1), .o(o1), .cout(c1), .busy(busy1));

  task automatic chk(input string n, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  function automatic logic [128:0] ref0(input logic [127:0] a, input logic [127:0] b, input logic ci, input logic s);
    return s ? {1'b0, a} + {1'b0, ~b} + 129'd1 : {1'b0, a} + {1'b0, b} + {128'd0, ci};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic accept0(input logic [127:0] a, input logic [127:0] b, input logic ci, input logic s);
    int n = 0;
    logic se = 0;
`ifdef MULTICYCLE_ADDER_SUB_EN
    se = s;
    sub0 = s;
`endif
    @(negedge clk);
    while (!ir0 && n < 50) begin @(negedge clk); n++; end
    if (!ir0) chk("accept_timeout0", 0, 1);
    a0 = a; b0 = b; cin0 = ci; iv0 = 1;
    q0.push_back(ref0(a, b, ci, se));
    @(posedge clk); #1;
    iv0 = 0;
    chk("busy_after_accept0", {ir0, busy0}, 2'b01);
  endtask

  task automatic finish0();
    int k = 0;
    bit low = 1;
    do begin
      @(posedge clk); #1; k++;
      if (ir0) low = 0;
    end while (!ov0 && k < 20);
    chk("latency0", k, 4);
    chk("in_ready_low0", low, 1);
  endtask

  task automatic run1(input logic [39:0] a, input logic [39:0] b, input logic ci);
    int n = 0;
    @(negedge clk);
    while (!ir1 && n < 50) begin @(negedge clk); n++; end
    if (!ir1) chk("accept_timeout1", 0, 1);
    a1 = a; b1 = b; cin1 = ci; iv1 = 1;
    q1.push_back(41'(a) + 41'(b) + 41'(ci));
    @(posedge clk); #1;
    iv1 = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ov1 && n < 20);
    chk("latency1", n, 3);
  endtask

  always @(negedge clk)
    if (rst_n && ov0 && or0) begin
      if (q0.size() == 0) chk("unexpected_result0", 1, 0);
      else chk("result0", {c0, o0}, q0.pop_front());
    end

  always @(negedge clk)
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) chk("unexpected_result1", 1, 0);
      else chk("result1", {88'd0, c1, o1}, {88'd0, q1.pop_front()});
    end

  initial forever begin
    @(posedge clk); #2;
    if (rnd) or0 = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ra, rb;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_flags0", {ir0, ov0, busy0, c0}, 4'b1000);
    chk("rst_o0", o0, 0);
    chk("rst_flags1", {ir1, ov1, busy1, c1}, 4'b1000);
    chk("rst_o1", o1, 0);
    rst_n = 1;
    or0 = 1;
    accept0(1, 2, 0, 0);
    finish0();
    accept0({128{1'b1}}, 1, 0, 0);
    finish0();
    run1({40{1'b1}}, 0, 1);
    run1(40'h12_3456_789A, 40'hFF_0000_FFFF, 0);
    // hold the result in DONE while a new request is pending
    or0 = 0;
    accept0(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0001, 1, 0);
    finish0();
    iv0 = 1; a0 = 128'd99;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_result0", {c0, o0}, ref0(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0001, 1, 0));
      chk("hold_flags0", {ir0, ov0}, 2'b01);
    end
    iv0 = 0; or0 = 1;
    @(posedge clk); #1;
    chk("handoff_idle0", {ir0, ov0, busy0}, 3'b100);
    // reset during the second RUN cycle
    accept0(128'd1000, 128'd2000, 0, 0);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("midrun_rst_flags0", {ir0, ov0, busy0, c0}, 4'b1000);
    chk("midrun_rst_o0", o0, 0);
    q0.delete();
    @(negedge clk);
    rst_n = 1;
    accept0(5, 7, 0, 0);
    finish0();
`ifdef MULTICYCLE_ADDER_SUB_EN
    accept0(5, 7, 0, 1);
    finish0();
    accept0(7, 5, 1, 1);
    finish0();
`endif
    rnd = 1;
    repeat (40) begin
      ra = r128();
      rb = r128();
      case ($urandom_range(0, 3))
        0: ra = {128{1'b1}};
        1: rb = ~ra;
        2: begin ra = {96'd0, ra[31:0]}; rb = {96'd0, rb[31:0]}; end
        default: ;
      endcase
      accept0(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (15) run1(40'(r128()), 40'(r128()), 1'($urandom_range(0, 1)));
    rnd = 0;
    @(posedge clk); #2;
    or0 = 1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
